// File: rtl/criq_reader.sv
// Consumer end of a circular request queue: pops queue entries into a 2-entry
// skid buffer and delivers them downstream over a valid/ready handshake.
module criq_reader #(
  parameter int DATAWIDE = 32,
  parameter int CNTWIDE  = 16,
  parameter int FLUSHCYC = 2
) (
  input  logic                Clk,
  input  logic                Rest,
  input  logic                Stall,
  input  logic                Flush,
  input  logic [DATAWIDE-1:0] QueuePreOut,
  input  logic                QueueEmpty,
  output logic                QueueRable,
  output logic                QueueClean,
  output logic                OutValid,
  output logic [DATAWIDE-1:0] OutData,
  input  logic                OutReady,
  output logic                Busy,
  output logic [CNTWIDE-1:0]  DeliverCnt
);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  localparam logic [3:0]         FLUSH_LAST = 4'(FLUSHCYC - 1);
  localparam logic [CNTWIDE-1:0] CNT_ONE    = CNTWIDE'(1);

  state_t              r_state;
  logic [3:0]          r_flush_cnt;
  logic [1:0]          r_count;
  logic [DATAWIDE-1:0] r_head;
  logic [DATAWIDE-1:0] r_tail;
  logic [CNTWIDE-1:0]  r_deliver_cnt;

  logic w_xfer;
  logic w_room;
  logic w_push;

  // The buffer is held empty in FLUSH, so occupancy alone gives valid.
  assign OutValid   = (r_count != 2'd0);
  assign OutData    = r_head;
  assign Busy       = (r_state == ST_FLUSH) | (r_count != 2'd0);
  assign DeliverCnt = r_deliver_cnt;

  assign w_xfer = OutValid & OutReady;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_room = 1'b0;
    case (r_count)
      2'd0, 2'd1: w_room = 1'b1;
      2'd2:       w_room = w_xfer;
      default:    w_room = 1'b0;
    endcase
  end

  // Strobes are gated by reset so nothing reaches the queue while held in reset.
  assign w_push     = Rest & (r_state == ST_RUN) & ~Flush & ~Stall & ~QueueEmpty & w_room;
  assign QueueRable = w_push;
  assign QueueClean = Rest & Flush;

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      r_state     <= ST_RUN;
      r_flush_cnt <= 4'd0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (Flush) begin
            r_state     <= ST_FLUSH;
            r_flush_cnt <= 4'd0;
          end
        end
        ST_FLUSH: begin
          if (Flush) begin
            r_flush_cnt <= 4'd0;
          end else if (r_flush_cnt == FLUSH_LAST) begin
            r_state     <= ST_RUN;
            r_flush_cnt <= 4'd0;
          end else begin
            r_flush_cnt <= r_flush_cnt + 4'd1;
          end
        end
        default: begin
          r_state     <= ST_RUN;
          r_flush_cnt <= 4'd0;
        end
      endcase
    end
  end

  // Shift-style FIFO: r_head is always the oldest entry and reads as zero when empty.
  // NOTE: the two data slots are reset because OutData must read zero out of reset.
  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      r_count <= 2'd0;
      r_head  <= '0;
      r_tail  <= '0;
    end else if (Flush) begin
      r_count <= 2'd0;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      case ({w_push, w_xfer})
        2'b11: begin
          if (r_count == 2'd1) begin
            r_head <= QueuePreOut;
          end else begin
            r_head <= r_tail;
            r_tail <= QueuePreOut;
          end
        end
        2'b10: begin
          if (r_count == 2'd0) begin
            r_head  <= QueuePreOut;
            r_count <= 2'd1;
          end else begin
            r_tail  <= QueuePreOut;
            r_count <= 2'd2;
          end
        end
        2'b01: begin
          if (r_count == 2'd1) begin
            r_head  <= '0;
            r_count <= 2'd0;
          end else begin
            r_head  <= r_tail;
            r_tail  <= '0;
            r_count <= 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // A head accepted in the flush cycle still counts as delivered.
  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      r_deliver_cnt <= '0;
    end else if (w_xfer) begin
      r_deliver_cnt <= r_deliver_cnt + CNT_ONE;
    end
  end

endmodule
